// File: rtl/sync_event_ctrl.sv
// sync_event_ctrl
//   Synchronizes NCH asynchronous level inputs, debounces each one, and turns
//   every debounced level change into an event. Events leave through a single
//   valid/ready port, and channels take turns round-robin. Each channel holds
//   at most one undelivered event. A further change on that channel while its
//   event is still waiting is dropped and recorded in a sticky overflow flag.
//
// Parameters
//   NCH          number of input channels (2..16)
//   SYNC_STAGES  synchronizer depth per channel (2..4)
//   DEBOUNCE     consecutive differing cycles needed to accept a change (1..255)
//
// Ports
//   CLK        clock for all logic
//   nRST       asynchronous active-low reset
//   in         raw asynchronous levels, one bit per channel
//   level      debounced level per channel
//   evt_valid  event presented
//   evt_ready  consumer accepts the presented event
//   evt_chan   channel index of the presented event
//   evt_level  new level carried by the event (1 rise, 0 fall)
//   overflow   sticky per-channel dropped-event flag
//   ovf_clr    one-cycle pulse clears the matching overflow bits
//   evt_time   (SYNC_EVENT_TIMESTAMP_EN only) cycle count captured at the flip
//
// Build option
//   SYNC_EVENT_TIMESTAMP_EN adds a free-running 16-bit cycle counter. The
//   counter value is captured per channel at each level flip and presented
//   on evt_time alongside evt_chan.

module sync_event_ctrl #(
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 8
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic [NCH-1:0]         in,
  output logic [NCH-1:0]         level,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [$clog2(NCH)-1:0] evt_chan,
  output logic                   evt_level,
  output logic [NCH-1:0]         overflow,
  input  logic [NCH-1:0]         ovf_clr
`ifdef SYNC_EVENT_TIMESTAMP_EN
  ,
  output logic [15:0]            evt_time
`endif
);

  localparam int CW = $clog2(NCH);
  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE - 1);

  logic [NCH-1:0][SYNC_STAGES-1:0] sync_ff;
  logic [NCH-1:0][7:0]             db_cnt;
  logic [NCH-1:0]                  synced;
  logic [NCH-1:0]                  differ;
  logic [NCH-1:0]                  flip;
  logic [NCH-1:0]                  pending;
  logic [NCH-1:0]                  pend_lvl;
  logic [NCH-1:0]                  ovf_set;
  logic [NCH-1:0]                  grant_vec;
  logic [CW-1:0]                   last_grant;
  logic [CW-1:0]                   grant_idx;
  logic [CW-1:0]                   cand;
  logic                            grant_vld;
  logic                            load;

  always_comb begin
    synced  = '0;
    differ  = '0;
    flip    = '0;
    for (int i = 0; i < NCH; i++) begin
      synced[i] = sync_ff[i][SYNC_STAGES-1];
      differ[i] = synced[i] ^ level[i];
      // The flip happens on the DEBOUNCE-th differing cycle. The counter
      // still holds the number of earlier differing cycles.
      flip[i]   = differ[i] && (db_cnt[i] == DB_LAST);
    end
  end

  // Round-robin search starts just after the last granted channel.
  always_comb begin
    load      = !evt_valid || evt_ready;
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_vec = '0;
    cand      = '0;
    if (load) begin
      for (int k = 1; k <= NCH; k++) begin
        cand = CW'((int'(last_grant) + k) % NCH);
        if (!grant_vld && pending[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_vld) grant_vec[grant_idx] = 1'b1;
  end

  // A new flip is dropped only when the channel's slot is still occupied.
  // A slot being granted this cycle counts as free.
  always_comb begin
    ovf_set = flip & pending & ~grant_vec;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync_ff    <= '0;
      db_cnt     <= '0;
      level      <= '0;
      pending    <= '0;
      pend_lvl   <= '0;
      overflow   <= '0;
      evt_valid  <= 1'b0;
      evt_chan   <= '0;
      evt_level  <= 1'b0;
      last_grant <= CW'(NCH - 1);
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sync_ff[i] <= {sync_ff[i][SYNC_STAGES-2:0], in[i]};

        if (!differ[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          db_cnt[i] <= '0;
          level[i]  <= ~level[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 8'd1;
        end

        if (flip[i] && !ovf_set[i]) begin
          pending[i]  <= 1'b1;
          pend_lvl[i] <= ~level[i];
        end else if (grant_vec[i]) begin
          pending[i]  <= 1'b0;
        end
      end

      // A same-cycle set beats the clear.
      overflow <= (overflow & ~ovf_clr) | ovf_set;

      if (load) begin
        evt_valid <= grant_vld;
        if (grant_vld) begin
          evt_chan   <= grant_idx;
          evt_level  <= pend_lvl[grant_idx];
          last_grant <= grant_idx;
        end
      end
    end
  end

`ifdef SYNC_EVENT_TIMESTAMP_EN
  logic [15:0]           ts_cnt;
  logic [NCH-1:0][15:0]  pend_time;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ts_cnt    <= '0;
      pend_time <= '0;
      evt_time  <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      for (int i = 0; i < NCH; i++) begin
        if (flip[i] && !ovf_set[i]) pend_time[i] <= ts_cnt;
      end
      if (load && grant_vld) evt_time <= pend_time[grant_idx];
    end
  end
`endif

endmodule
